serial_cmp_ctrl: RTL and testbench

- Sequencer that compares two W-bit operands using one external 1-bit magnitude comparator (inputs a/b, one-hot outputs e/g/l).
- Walks the operands MSB-first, one bit per clock, and stops at the first differing bit.
- Accepts operands over a valid/ready handshake and returns a held eq/gt/lt result over a second valid/ready handshake.
- Sits between operand producers and the shared single-bit comparator; the comparator stays purely combinational.

---
 rtl/serial_cmp_ctrl_if.sv | 38 +++
 rtl/serial_cmp_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_ctrl_if
// Description : Operand and result handshake bundle for serial_cmp_ctrl.
//               master = operand producer / result consumer side,
//               slave  = the compare sequencer.
// Ports       : in_valid/in_ready/in_a/in_b  operand handshake
//               res_valid/res_ready          result handshake
//               res_eq/res_gt/res_lt/res_err held one-hot result
//               busy                         scan in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_cmp_ctrl_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         busy;
   logic         res_valid;
   logic         res_ready;
   logic         res_eq;
   logic         res_gt;
   logic         res_lt;
   logic         res_err;

   modport master (
      output in_valid, in_a, in_b, res_ready,
      input  in_ready, busy, res_valid, res_eq, res_gt, res_lt, res_err
   );

   modport slave (
      input  in_valid, in_a, in_b, res_ready,
      output in_ready, busy, res_valid, res_eq, res_gt, res_lt, res_err
   );
endinterface
`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_ctrl
// Description : MSB-first serial magnitude compare sequencer driving one
//               external combinational 1-bit comparator. Operands arrive on
//               a valid/ready handshake, one bit pair is presented per clock,
//               and a held eq/gt/lt/err result leaves on a second handshake.
// Ports       : clk         rising-edge clock
//               rst_n       asynchronous active-low reset
//               bus         operand/result handshake (slave modport)
//               cmp_a/cmp_b bit pair driven to the comparator
//               cmp_e/g/l   comparator one-hot response
// Parameters  : W           operand width (>= 1)
//               EARLY_EXIT  1 = stop at first difference, 0 = fixed W cycles
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmp_ctrl #(
   parameter int W          = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   serial_cmp_ctrl_if.slave bus,
   output logic             cmp_a,
   output logic             cmp_b,
   input  logic             cmp_e,
   input  logic             cmp_g,
   input  logic             cmp_l
);

   // Index width kept at least 1 so W = 1 still has a legal register.
   localparam int             C_IW      = (W > 1) ? $clog2(W) : 1;
   localparam logic [C_IW-1:0] C_IDX_MAX = C_IW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state,    w_state_nxt;
   logic [C_IW-1:0] r_idx,      w_idx_nxt;
   logic [W-1:0]    r_op_a,     w_op_a_nxt;
   logic [W-1:0]    r_op_b,     w_op_b_nxt;
   logic            r_decided,  w_decided_nxt;
   logic            r_in_ready, w_in_ready_nxt;
   logic            r_eq,       w_eq_nxt;
   logic            r_gt,       w_gt_nxt;
   logic            r_lt,       w_lt_nxt;
   logic            r_err,      w_err_nxt;

   logic            w_onehot;
   logic            w_diff;
   logic            w_scan;
   logic            w_done;

   // Exactly one of three set: odd parity rules out 0 and 2, AND rules out 3.
   assign w_onehot = (cmp_e ^ cmp_g ^ cmp_l) & ~(cmp_e & cmp_g & cmp_l);
   assign w_diff   = cmp_g | cmp_l;
   assign w_scan   = (r_state == ST_SCAN);
   assign w_done   = (r_state == ST_DONE);

   // ---------------------------------------------------------------------
   // State register (and the datapath registers that move with it)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= C_IDX_MAX;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_decided  <= 1'b0;
         r_in_ready <= 1'b0;
         r_eq       <= 1'b0;
         r_gt       <= 1'b0;
         r_lt       <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_op_a     <= w_op_a_nxt;
         r_op_b     <= w_op_b_nxt;
         r_decided  <= w_decided_nxt;
         r_in_ready <= w_in_ready_nxt;
         r_eq       <= w_eq_nxt;
         r_gt       <= w_gt_nxt;
         r_lt       <= w_lt_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_op_a_nxt    = r_op_a;
      w_op_b_nxt    = r_op_b;
      w_decided_nxt = r_decided;
      w_eq_nxt      = r_eq;
      w_gt_nxt      = r_gt;
      w_lt_nxt      = r_lt;
      w_err_nxt     = r_err;

      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid && r_in_ready) begin
               w_state_nxt   = ST_SCAN;
               w_op_a_nxt    = bus.in_a;
               w_op_b_nxt    = bus.in_b;
               w_idx_nxt     = C_IDX_MAX;
               w_decided_nxt = 1'b0;
               w_eq_nxt      = 1'b0;
               w_gt_nxt      = 1'b0;
               w_lt_nxt      = 1'b0;
               w_err_nxt     = 1'b0;
            end
         end

         ST_SCAN: begin
            if (!w_onehot) begin
               // A broken comparator response overrides any decision so far.
               w_state_nxt = ST_DONE;
               w_err_nxt   = 1'b1;
               w_eq_nxt    = 1'b0;
               w_gt_nxt    = 1'b0;
               w_lt_nxt    = 1'b0;
            end else if (w_diff && !r_decided && EARLY_EXIT) begin
               w_state_nxt = ST_DONE;
               w_gt_nxt    = cmp_g;
               w_lt_nxt    = cmp_l;
            end else begin
               // Only the first difference counts; later ones are ignored.
               if (w_diff && !r_decided) begin
                  w_gt_nxt      = cmp_g;
                  w_lt_nxt      = cmp_l;
                  w_decided_nxt = 1'b1;
               end
               if (r_idx == '0) begin
                  // Includes a first difference found on the LSB itself.
                  w_state_nxt = ST_DONE;
                  w_eq_nxt    = ~w_decided_nxt;
               end else begin
                  w_idx_nxt = r_idx - 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (bus.res_ready) begin
               w_state_nxt   = ST_IDLE;
               w_eq_nxt      = 1'b0;
               w_gt_nxt      = 1'b0;
               w_lt_nxt      = 1'b0;
               w_err_nxt     = 1'b0;
               w_decided_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Registered ready: high exactly while the machine sits in IDLE,
      // which also gives the one-edge delay after reset release.
      w_in_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.in_ready  = r_in_ready;
   assign bus.busy      = w_scan;
   assign bus.res_valid = w_done;
   // Latched gt/lt of a fixed-time scan stay hidden until the result is due.
   assign bus.res_eq    = r_eq  & w_done;
   assign bus.res_gt    = r_gt  & w_done;
   assign bus.res_lt    = r_lt  & w_done;
   assign bus.res_err   = r_err & w_done;

   assign cmp_a = w_scan ? r_op_a[r_idx] : 1'b0;
   assign cmp_b = w_scan ? r_op_b[r_idx] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_cmp_ctrl
// Description : Self-checking bench for serial_cmp_ctrl. Two instances
//               (EARLY_EXIT = 1 and 0) receive the same operands; each has
//               its own 1-bit comparator model, the early-exit one can be
//               overridden with a bad response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cmp_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   serial_cmp_ctrl_if #(.W(W)) bx ();   // early-exit instance
   serial_cmp_ctrl_if #(.W(W)) bc ();   // constant-time instance

   logic       xa, xb, xe, xg, xl;
   logic       ca, cb, ce, cg, cl;
   logic       ovr_en;
   logic [2:0] ovr_val;

   always_comb begin
      {xe, xg, xl} = ovr_en ? ovr_val : {xa == xb, xa & ~xb, ~xa & xb};
      {ce, cg, cl} = {ca == cb, ca & ~cb, ~ca & cb};
   end

   serial_cmp_ctrl #(.W(W), .EARLY_EXIT(1'b1)) u_dut_x (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bx),
      .cmp_a (xa),
      .cmp_b (xb),
      .cmp_e (xe),
      .cmp_g (xg),
      .cmp_l (xl)
   );

   serial_cmp_ctrl #(.W(W), .EARLY_EXIT(1'b0)) u_dut_c (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bc),
      .cmp_a (ca),
      .cmp_b (cb),
      .cmp_e (ce),
      .cmp_g (cg),
      .cmp_l (cl)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
      bx.in_valid = v; bx.in_a = a; bx.in_b = b;
      bc.in_valid = v; bc.in_a = a; bc.in_b = b;
   endtask

   function automatic logic [3:0] res_x();
      return {bx.res_eq, bx.res_gt, bx.res_lt, bx.res_err};
   endfunction

   function automatic logic [3:0] res_c();
      return {bc.res_eq, bc.res_gt, bc.res_lt, bc.res_err};
   endfunction

   // One operation on both instances. Expected result {eq,gt,lt,err} and
   // latency come from plain integer arithmetic on the operands.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit inj, input logic [2:0] injv);
      int         d, p, kx, kc, lat_x, lat_c;
      logic [3:0] ex, ec;
      d  = int'(a ^ b);
      ec = (a == b) ? 4'b1000 : ((a > b) ? 4'b0100 : 4'b0010);
      kc = W;
      ex = ec;
      if (d == 0) kx = W;
      else begin
         p  = $clog2(d + 1) - 1;          // position of highest differing bit
         kx = W - p;
      end
      if (inj) begin
         ex = 4'b0001;
         kx = 1;
      end

      chk("idle_in_ready_x", bx.in_ready, 1);
      chk("idle_in_ready_c", bc.in_ready, 1);
      ovr_en  = inj;
      ovr_val = injv;
      drive(1'b1, a, b);
      @(posedge clk); #1;
      drive(1'b0, a, b);
      chk("scan_busy_x", bx.busy, 1);
      chk("scan_in_ready_x", bx.in_ready, 0);
      chk("scan_cmp_a_x", xa, a[W-1]);
      chk("scan_cmp_b_x", xb, b[W-1]);
      chk("scan_cmp_a_c", ca, a[W-1]);

      lat_x = -1;
      lat_c = -1;
      for (int cyc = 1; cyc <= 2 * W + 4 && (lat_x < 0 || lat_c < 0); cyc++) begin
         @(posedge clk); #1;
         if (lat_x < 0 && bx.res_valid === 1'b1) lat_x = cyc;
         if (lat_c < 0 && bc.res_valid === 1'b1) lat_c = cyc;
      end
      ovr_en = 1'b0;
      chk("latency_x", lat_x, kx);
      chk("latency_c", lat_c, kc);
      chk("result_x", res_x(), ex);
      chk("result_c", res_c(), ec);
      chk("done_busy_x", bx.busy, 0);

      for (int h = 0; h < hold; h++) begin
         drive(~bx.in_valid, W'($urandom), W'($urandom));
         @(posedge clk); #1;
         chk("hold_valid_x", bx.res_valid, 1);
         chk("hold_result_x", res_x(), ex);
         chk("hold_result_c", res_c(), ec);
         chk("hold_in_ready_x", bx.in_ready, 0);
      end
      drive(1'b0, a, b);

      bx.res_ready = 1'b1;
      bc.res_ready = 1'b1;
      @(posedge clk); #1;
      bx.res_ready = 1'b0;
      bc.res_ready = 1'b0;
      chk("release_valid_x", bx.res_valid, 0);
      chk("release_valid_c", bc.res_valid, 0);
      chk("release_in_ready_x", bx.in_ready, 1);
      chk("release_result_x", res_x(), 0);
      chk("idle_cmp_x", {xa, xb}, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, {bx.in_ready, bx.busy, bx.res_valid, res_x(), xa, xb}, 0);
      chk({tag, "_c"}, {bc.in_ready, bc.busy, bc.res_valid, res_c(), ca, cb}, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst_n        = 1'b0;
      ovr_en       = 1'b0;
      ovr_val      = 3'b000;
      bx.res_ready = 1'b0;
      bc.res_ready = 1'b0;
      drive(1'b0, '0, '0);

      // Reset state and ready timing after release
      #1;
      chk_all_zero("reset_state");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("pre_edge_in_ready", bx.in_ready, 0);
      @(posedge clk); #1;
      chk("post_edge_in_ready", bx.in_ready, 1);

      // Directed compares
      do_op(8'hA5, 8'hA5, 0, 1'b0, 3'b000);   // equal, full scan
      do_op(8'h80, 8'h7F, 0, 1'b0, 3'b000);   // MSB decides, later bits ignored
      do_op(8'h12, 8'h13, 0, 1'b0, 3'b000);   // LSB decides
      do_op(8'hC3, 8'h3C, 5, 1'b0, 3'b000);   // result held under backpressure
      do_op(8'h3C, 8'hC3, 0, 1'b0, 3'b000);   // back-to-back after release

      // Bad comparator responses
      do_op(8'h5A, 8'h5A, 0, 1'b1, 3'b110);
      do_op(8'h5A, 8'h4A, 0, 1'b1, 3'b000);

      // Reset on the third scan cycle
      drive(1'b1, 8'h01, 8'h00);
      @(posedge clk); #1;
      drive(1'b0, 8'h01, 8'h00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_scan_busy_x", bx.busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("reset_no_valid", {bx.res_valid, bc.res_valid}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_pre_in_ready", bx.in_ready, 0);
      @(posedge clk); #1;
      chk("rel_post_in_ready", bx.in_ready, 1);
      do_op(8'h01, 8'h00, 0, 1'b0, 3'b000);

      // Randomized compares: equal, single-bit difference, or unrelated
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         do_op(ra, rb, int'($urandom_range(0, 2)), 1'b0, 3'b000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
